uart_echo_responder: RTL and testbench
======================================

// Module: uart_echo_responder
// PURPOSE
// Link-side responder between the UART receiver and transmitter: every byte
// the receiver delivers is buffered in a small FIFO and sent back through the
// transmitter, XORed with a fixed mask. Provides board loopback and link
// self-test without a host. Decouples receiver and transmitter timing so
// back-to-back received bytes are not lost while the transmitter is busy.
// PARAMETERS
// DEPTH     8      FIFO entries; power of 2, >= 2
// XOR_MASK  8'h00  byte XORed onto each echoed byte (8'h20 = ASCII case flip)
// PORTS
// clk          in   1            system clock
// rstn         in   1            reset, synchronous, active-low
// rx_ready     in   1            receiver byte-valid; held high until cleared
// rx_data      in   8            receiver byte, valid while rx_ready=1
// rx_ready_clr out  1            clear request to receiver
// tx_data      out  8            byte to transmitter; stable from tx_en until done
// tx_en        out  1            one-cycle start strobe to transmitter
// tx_busy      in   1            transmitter busy
// enable       in   1            1 = start new echoes; 0 = buffer only
// ovf_clr      in   1            clears sticky overflow flag
// overflow     out  1            sticky: a byte was dropped, FIFO full
// fifo_count   out  $clog2(DEPTH)+1  bytes currently buffered
// BEHAVIOUR
// Reset (rstn=0 at clk edge): FIFO emptied, both FSMs idle; rx_ready_clr=0,
//  tx_en=0, tx_data=0, overflow=0, fifo_count=0. Reset mid-frame abandons the
//  byte in flight; no tx_en is issued for it afterwards.
// RX FSM:
//  R_IDLE: rx_ready=1 -> push rx_data (if room), go R_CLR; rx_ready_clr=1
//   registered, so it is high the cycle after capture.
//  R_CLR: hold rx_ready_clr=1 until rx_ready=0, then rx_ready_clr=0, R_IDLE.
//   Guarantees exactly one push per received byte.
//  Full FIFO at capture: byte dropped, overflow set, clear handshake still done.
//   Exception: push and pop in the same cycle at full -> push accepted,
//   count unchanged, no overflow.
//  ovf_clr and a new overflow in the same cycle -> overflow stays 1.
// TX FSM:
//  T_IDLE: enable=1 and count>0 -> pop head into tx_data, tx_en=1 for exactly
//   one cycle, go T_WAIT_BUSY.
//  T_WAIT_BUSY: wait for tx_busy=1 (may already be 1) -> T_WAIT_DONE.
//  T_WAIT_DONE: wait for tx_busy=0 -> T_IDLE. Next tx_en no earlier than the
//   cycle after tx_busy falls.
//  enable dropping mid-byte finishes the current byte; no new start.
// tx_data = FIFO head XOR XOR_MASK, registered at pop; unchanged until the
//  next pop.
// FIFO: circular, read/write pointers wrap modulo DEPTH; count range
//  0..DEPTH; count = DEPTH is full, 0 is empty; order preserved (FIFO).
// Latency: rx_ready rising at cycle N with empty FIFO, enable=1, TX idle ->
//  push at N, tx_en at N+1 (one-cycle read of pushed entry), no bypass path.
// TESTING
// 1 rx byte 8'h41, XOR_MASK=8'h20, enable=1 -> one rx_ready_clr, tx_en pulse
//   1 cycle, tx_data=8'h61; fifo_count 1 then 0.
// 2 Model tx_busy for 100 cycles; send 8'h01..8'h05 back to back -> echoed
//   in order 01..05, one tx_en per byte, each after tx_busy falls.
// 3 enable=0, send DEPTH+1 bytes -> fifo_count=DEPTH, overflow=1, all clears
//   done; enable=1 -> exactly DEPTH bytes echoed; ovf_clr -> overflow=0.
// 4 Full FIFO, tx pop and rx push in same cycle -> count stays DEPTH,
//   overflow stays 0, new byte echoed last.
// 5 rstn=0 during T_WAIT_DONE with 3 bytes queued -> next cycle count=0,
//   tx_en=0, rx_ready_clr=0; no tx_en after release until a new rx byte.
// 6 rx_ready held high 10 cycles after clear request -> only one push.

Source files
------------

// File: rtl/uart_echo_responder.sv
// uart_echo_responder
// Echoes every byte delivered by the UART receiver back through the UART
// transmitter, XORed with XOR_MASK. A small circular FIFO decouples the
// receive and transmit sides so back-to-back bytes survive a busy transmitter.
//
// Ports
//   clk, rstn     : clock, synchronous active-low reset
//   rx_ready      : receiver byte-valid, held until rx_ready_clr is seen
//   rx_data       : received byte, valid while rx_ready is high
//   rx_ready_clr  : clear request back to the receiver (registered)
//   tx_data       : echoed byte, stable from tx_en until the next pop
//   tx_en         : one-cycle start strobe to the transmitter
//   tx_busy       : transmitter busy
//   enable        : 1 = start new echoes, 0 = buffer only
//   ovf_clr       : clears the sticky overflow flag
//   overflow      : sticky, a byte was dropped because the FIFO was full
//   fifo_count    : bytes currently buffered (0..DEPTH)
module uart_echo_responder #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [7:0]  XOR_MASK = 8'h00
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx_ready,
  input  logic [7:0]               rx_data,
  output logic                     rx_ready_clr,
  output logic [7:0]               tx_data,
  output logic                     tx_en,
  input  logic                     tx_busy,
  input  logic                     enable,
  input  logic                     ovf_clr,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    R_IDLE,
    R_CLR
  } rx_state_e;

  typedef enum logic [1:0] {
    T_IDLE,
    T_WAIT_BUSY,
    T_WAIT_DONE
  } tx_state_e;

  rx_state_e          rx_state_q, rx_state_d;
  tx_state_e          tx_state_q, tx_state_d;
  logic [7:0]         mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               rx_clr_q, rx_clr_d;
  logic               tx_en_q, tx_en_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               ovf_q, ovf_d;
  logic               push;
  logic               pop;
  logic               drop;
  logic               full;

  // Next-state logic for both FSMs and the FIFO bookkeeping
  always_comb begin
    rx_state_d = rx_state_q;
    tx_state_d = tx_state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    rx_clr_d   = rx_clr_q;
    tx_en_d    = 1'b0;
    tx_data_d  = tx_data_q;
    ovf_d      = ovf_q & ~ovf_clr;
    push       = 1'b0;
    pop        = 1'b0;
    drop       = 1'b0;
    full       = (count_q == CNT_W'(DEPTH));

    // Transmit side: pop the head from the registered count, so a byte
    // pushed this cycle is read one cycle later (no bypass).
    case (tx_state_q)
      T_IDLE: begin
        if (enable && (count_q != '0)) begin
          pop        = 1'b1;
          tx_data_d  = mem_q[rptr_q] ^ XOR_MASK;
          tx_en_d    = 1'b1;
          tx_state_d = T_WAIT_BUSY;
        end
      end
      T_WAIT_BUSY: begin
        if (tx_busy) tx_state_d = T_WAIT_DONE;
      end
      T_WAIT_DONE: begin
        if (!tx_busy) tx_state_d = T_IDLE;
      end
      default: tx_state_d = T_IDLE;
    endcase

    // Receive side: one capture per rx_ready assertion; a pop in the same
    // cycle frees the slot, so a full FIFO still accepts the byte then.
    case (rx_state_q)
      R_IDLE: begin
        if (rx_ready) begin
          if (!full || pop) push = 1'b1;
          else              drop = 1'b1;
          rx_clr_d   = 1'b1;
          rx_state_d = R_CLR;
        end
      end
      R_CLR: begin
        if (!rx_ready) begin
          rx_clr_d   = 1'b0;
          rx_state_d = R_IDLE;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase

    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (drop) ovf_d = 1'b1;
  end

  // State, FIFO storage and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_state_q <= R_IDLE;
      tx_state_q <= T_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rx_clr_q   <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      ovf_q      <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rx_clr_q   <= rx_clr_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
      ovf_q      <= ovf_d;
      if (push) mem_q[wptr_q] <= rx_data;
    end
  end

  assign rx_ready_clr = rx_clr_q;
  assign tx_en        = tx_en_q;
  assign tx_data      = tx_data_q;
  assign overflow     = ovf_q;
  assign fifo_count   = count_q;

endmodule

// File: tb/tb_uart_echo_responder.sv
// tb_uart_echo_responder
// Self-checking bench for uart_echo_responder (DEPTH=8, XOR_MASK=8'h20).
// A queue-based reference model predicts every registered output each cycle;
// directed scenarios add literal expectations, then a randomized run follows.
`timescale 1ns/1ps
module tb_uart_echo_responder;

  localparam int unsigned DEPTH = 8;
  localparam logic [7:0]  MASK  = 8'h20;

  logic       clk      = 1'b0;
  logic       rstn     = 1'b0;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       tx_busy  = 1'b0;
  logic       enable   = 1'b0;
  logic       ovf_clr  = 1'b0;
  logic       rx_ready_clr;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       overflow;
  logic [3:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_echo_responder #(
    .DEPTH    (DEPTH),
    .XOR_MASK (MASK)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_ready_clr (rx_ready_clr),
    .tx_data      (tx_data),
    .tx_en        (tx_en),
    .tx_busy      (tx_busy),
    .enable       (enable),
    .ovf_clr      (ovf_clr),
    .overflow     (overflow),
    .fifo_count   (fifo_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: a byte queue, a "clear handshake outstanding" flag and
  // the transmitter phase (0 idle, 1 started/awaiting busy, 2 awaiting done).
  logic [7:0] mq [$];
  bit         m_clr   = 1'b0;
  bit         m_ten   = 1'b0;
  bit         m_ovf   = 1'b0;
  logic [7:0] m_tdata = 8'h00;
  int         m_phase = 0;

  always @(posedge clk) begin
    logic [7:0] head;
    bit start, take, drop;
    if (!rstn) begin
      mq.delete();
      m_clr = 1'b0; m_ten = 1'b0; m_ovf = 1'b0; m_tdata = 8'h00; m_phase = 0;
    end else begin
      start = (m_phase == 0) && enable && (mq.size() > 0);
      take  = !m_clr && rx_ready;
      drop  = 1'b0;
      if (start) begin
        head    = mq.pop_front();
        m_tdata = head ^ MASK;
      end
      m_ten = start;
      if (take) begin
        if (mq.size() < DEPTH) mq.push_back(rx_data);
        else                   drop = 1'b1;
      end
      m_ovf = (m_ovf && !ovf_clr) || drop;
      if (take)                    m_clr = 1'b1;
      else if (m_clr && !rx_ready) m_clr = 1'b0;
      if (start)                             m_phase = 1;
      else if (m_phase == 1 && tx_busy)      m_phase = 2;
      else if (m_phase == 2 && !tx_busy)     m_phase = 0;
    end
  end

  // Per-cycle compare against the model; also logs every echoed byte
  logic [7:0] echo_q [$];
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("rx_ready_clr", rx_ready_clr, m_clr);
      check("tx_en",        tx_en,        m_ten);
      check("tx_data",      tx_data,      m_tdata);
      check("overflow",     overflow,     m_ovf);
      check("fifo_count",   fifo_count,   mq.size());
      if (tx_en === 1'b1) echo_q.push_back(tx_data);
    end
  end

  // Transmitter stand-in: busy for busy_len cycles, busy_delay after tx_en
  int busy_delay = 0;
  int busy_len   = 3;
  initial forever begin
    @(negedge clk);
    if (tx_en === 1'b1) begin
      repeat (busy_delay) @(negedge clk);
      tx_busy = 1'b1;
      repeat (busy_len) @(negedge clk);
      tx_busy = 1'b0;
    end
  end

  // Receiver stand-in: present a byte, keep rx_ready for hold cycles after
  // the clear request, then complete the handshake.
  task automatic send_byte(input logic [7:0] b, input int hold);
    int t;
    rx_data  = b;
    rx_ready = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (rx_ready_clr !== 1'b1 && t < 50);
    check("clr_raise", rx_ready_clr, 1'b1);
    repeat (hold) @(negedge clk);
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
    t = 0;
    do begin @(negedge clk); t++; end while (rx_ready_clr !== 1'b0 && t < 50);
    check("clr_fall", rx_ready_clr, 1'b0);
  endtask

  task automatic wait_idle(input int max_cyc);
    int t;
    t = 0;
    while (!(mq.size() == 0 && m_phase == 0 && tx_busy == 1'b0) && t < max_cyc) begin
      @(negedge clk);
      t++;
    end
    check("drain_done", (mq.size() == 0 && m_phase == 0), 1);
  endtask

  initial begin #500000; $display("FAIL watchdog: time limit reached"); $fatal(1, "watchdog"); end

  initial begin
    int         base;
    int         t;
    logic [7:0] b;
    logic [7:0] sent [$];

    repeat (3) @(negedge clk);
    check("rst_fifo_count", fifo_count,   0);
    check("rst_tx_en",      tx_en,        0);
    check("rst_tx_data",    tx_data,      8'h00);
    check("rst_overflow",   overflow,     0);
    check("rst_clr",        rx_ready_clr, 0);

    // Single byte, one-cycle latency from push to tx_en
    rstn = 1'b1; enable = 1'b1;
    rx_data = 8'h41; rx_ready = 1'b1;
    @(negedge clk);
    check("t1_count_1",   fifo_count,   1);
    check("t1_clr_high",  rx_ready_clr, 1);
    check("t1_no_tx_yet", tx_en,        0);
    @(negedge clk);
    check("t1_tx_en",     tx_en,        1);
    check("t1_tx_data",   tx_data,      8'h61);
    check("t1_count_0",   fifo_count,   0);
    rx_ready = 1'b0;
    @(negedge clk);
    check("t1_tx_en_1cyc", tx_en,        0);
    check("t1_clr_low",    rx_ready_clr, 0);
    check("t1_data_held",  tx_data,      8'h61);
    wait_idle(100);
    check("t1_echo_count", echo_q.size(), 1);

    // Back-to-back bytes behind a slow transmitter
    busy_len = 100; base = echo_q.size();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 0);
    wait_idle(1000);
    check("t2_echo_count", echo_q.size() - base, 5);
    for (int i = 0; i < 5; i++) check("t2_order", echo_q[base + i], 8'(i + 1) ^ MASK);

    // Overflow with echo disabled, then drain exactly DEPTH bytes
    busy_len = 3; enable = 1'b0; sent.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom); sent.push_back(b); send_byte(b, 0);
    end
    check("t3_count_full", fifo_count, DEPTH);
    check("t3_overflow",   overflow,   1);
    base = echo_q.size(); enable = 1'b1;
    wait_idle(500);
    check("t3_echo_count", echo_q.size() - base, DEPTH);
    for (int i = 0; i < DEPTH; i++) check("t3_data", echo_q[base + i], sent[i] ^ MASK);
    check("t3_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("t3_ovf_cleared", overflow, 0);

    // Simultaneous pop and push at full
    enable = 1'b0; sent.delete();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom); sent.push_back(b); send_byte(b, 0);
    end
    check("t4_full", fifo_count, DEPTH);
    base = echo_q.size();
    b = 8'($urandom); sent.push_back(b);
    rx_data = b; rx_ready = 1'b1; enable = 1'b1;
    @(negedge clk);
    check("t4_count_same", fifo_count, DEPTH);
    check("t4_no_ovf",     overflow,   0);
    check("t4_tx_en",      tx_en,      1);
    check("t4_head",       tx_data,    sent[0] ^ MASK);
    rx_ready = 1'b0;
    @(negedge clk);
    check("t4_clr_low", rx_ready_clr, 0);
    wait_idle(500);
    check("t4_echo_count", echo_q.size() - base, DEPTH + 1);
    for (int i = 0; i <= DEPTH; i++) check("t4_data", echo_q[base + i], sent[i] ^ MASK);

    // Reset while waiting for the transmitter with 3 bytes queued
    enable = 1'b0; busy_len = 30;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
    enable = 1'b1;
    t = 0;
    while (m_phase != 2 && t < 20) begin @(negedge clk); t++; end
    check("t5_in_wait_done", m_phase, 2);
    check("t5_queued",       fifo_count, 3);
    rstn = 1'b0;
    @(negedge clk);
    check("t5_rst_count", fifo_count,   0);
    check("t5_rst_tx_en", tx_en,        0);
    check("t5_rst_clr",   rx_ready_clr, 0);
    check("t5_rst_data",  tx_data,      8'h00);
    rstn = 1'b1; base = echo_q.size();
    repeat (60) @(negedge clk);
    check("t5_no_tx_after_rst", echo_q.size() - base, 0);
    busy_len = 3;
    send_byte(8'h33, 0);
    wait_idle(100);
    check("t5_new_echo", echo_q[base], 8'h13);

    // rx_ready held long after the clear request: one push only
    enable = 1'b0;
    send_byte(8'h5a, 10);
    check("t6_one_push", fifo_count, 1);
    base = echo_q.size(); enable = 1'b1;
    wait_idle(100);
    check("t6_echo_count", echo_q.size() - base, 1);
    check("t6_echo_data",  echo_q[base], 8'h7a);

    // Randomized traffic, model compare every cycle
    for (int i = 0; i < 80; i++) begin
      enable     = ($urandom_range(0, 3) != 0);
      busy_len   = $urandom_range(1, 6);
      busy_delay = $urandom_range(0, 2);
      send_byte(8'($urandom), $urandom_range(0, 3));
      repeat ($urandom_range(0, 4)) begin
        ovf_clr = ($urandom_range(0, 5) == 0);
        @(negedge clk);
      end
      ovf_clr = 1'b0;
    end
    enable = 1'b1; busy_delay = 0;
    wait_idle(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
